caliptra_imem_port_arb: RTL and testbench

//  Shares the single-port IMEM SRAM between core instruction fetch (reads) and an external

---
 rtl/caliptra_imem_port_arb.sv | 150 +++++++++++++++
 tb/tb_caliptra_imem_port_arb.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/caliptra_imem_port_arb.sv
// IMEM port arbiter: core fetch vs buffered loader writes on one SRAM port.
// Define CALIPTRA_IMEM_ARB_FWD_EN to stall fetches that hit a queued write.
module caliptra_imem_port_arb #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                          clk,
    input  logic                          cptra_rst_b,
    input  logic                          core_cs,
    input  logic [ADDR_W-1:0]             core_addr,
    output logic                          core_stall,
    output logic [DATA_W-1:0]             core_rdata,
    input  logic                          ext_wr_valid,
    input  logic [ADDR_W-1:0]             ext_wr_addr,
    input  logic [DATA_W-1:0]             ext_wr_data,
    output logic                          ext_wr_ready,
    output logic                          sram_cs,
    output logic                          sram_we,
    output logic [ADDR_W-1:0]             sram_addr,
    output logic [DATA_W-1:0]             sram_wdata,
    input  logic [DATA_W-1:0]             sram_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        ST_CORE,
        ST_FORCE
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     count;
    logic [SW-1:0]     starve_cnt, starve_nxt;
    logic              active;
    logic              empty, full, push, pop, hazard;

    assign empty        = (count == '0);
    assign full         = (count == LW'(FIFO_DEPTH));
    // Held low until the first clock after reset so every output is 0 in reset.
    assign ext_wr_ready = active & ~full;
    assign push         = ext_wr_valid & ext_wr_ready;
    assign fifo_level   = count;
    assign busy         = ~empty;
    assign core_rdata   = active ? sram_rdata : '0;

`ifdef CALIPTRA_IMEM_ARB_FWD_EN
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (LW'(i) < count &&
                fifo_addr[rd_ptr + PW'(i)] == core_addr)
                hazard = 1'b1;
        end
        // A write landing this cycle is also a hazard for the fetch.
        if (push && ext_wr_addr == core_addr)
            hazard = 1'b1;
    end
`else
    assign hazard = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        pop        = 1'b0;
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        core_stall = 1'b0;
        if (active) begin
            unique case (state)
                ST_CORE: begin
                    if (core_cs && !hazard) begin
                        sram_cs   = 1'b1;
                        sram_addr = core_addr;
                        if (!empty && starve_cnt != SW'(STARVE_MAX))
                            starve_nxt = starve_cnt + 1'b1;
                    end else if (!empty) begin
                        pop        = 1'b1;
                        sram_cs    = 1'b1;
                        sram_we    = 1'b1;
                        sram_addr  = fifo_addr[rd_ptr];
                        sram_wdata = fifo_data[rd_ptr];
                        starve_nxt = '0;
                        core_stall = core_cs;
                    end else begin
                        core_stall = core_cs;
                    end
                    if (empty)
                        starve_nxt = '0;
                    if (!empty && starve_nxt == SW'(STARVE_MAX))
                        state_nxt = ST_FORCE;
                end
                ST_FORCE: begin
                    pop        = ~empty;
                    sram_cs    = ~empty;
                    sram_we    = ~empty;
                    sram_addr  = fifo_addr[rd_ptr];
                    sram_wdata = fifo_data[rd_ptr];
                    core_stall = core_cs;
                    starve_nxt = '0;
                    state_nxt  = ST_CORE;
                end
                default: state_nxt = ST_CORE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            active     <= 1'b0;
            state      <= ST_CORE;
            starve_cnt <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            active     <= 1'b1;
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= ext_wr_addr;
            fifo_data[wr_ptr] <= ext_wr_data;
        end
    end

endmodule

// File: tb/tb_caliptra_imem_port_arb.sv
// Randomized scoreboard bench for caliptra_imem_port_arb.
// Honours CALIPTRA_IMEM_ARB_FWD_EN when defined for the build.
module tb_caliptra_imem_port_arb;

    localparam int AW    = 13;
    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam int SMAX  = 8;

    logic          clk;
    logic          cptra_rst_b;
    logic          core_cs;
    logic [AW-1:0] core_addr;
    logic          core_stall;
    logic [DW-1:0] core_rdata;
    logic          ext_wr_valid;
    logic [AW-1:0] ext_wr_addr;
    logic [DW-1:0] ext_wr_data;
    logic          ext_wr_ready;
    logic          sram_cs;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;
    logic [$clog2(DEPTH):0] fifo_level;
    logic          busy;

    caliptra_imem_port_arb #(
        .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .cptra_rst_b(cptra_rst_b),
        .core_cs(core_cs), .core_addr(core_addr),
        .core_stall(core_stall), .core_rdata(core_rdata),
        .ext_wr_valid(ext_wr_valid), .ext_wr_addr(ext_wr_addr),
        .ext_wr_data(ext_wr_data), .ext_wr_ready(ext_wr_ready),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .fifo_level(fifo_level), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, a, e);
        end
    endtask

    // Environment SRAM: 1-cycle read latency, read data held across writes.
    logic [DW-1:0] sram_mem [0:(1<<AW)-1];
    logic [DW-1:0] shadow   [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            sram_mem[i] = '0;
            shadow[i]   = '0;
        end
        sram_rdata = '0;
    end
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) sram_mem[sram_addr] <= sram_wdata;
            else         sram_rdata <= sram_mem[sram_addr];
        end
    end

    logic act_m;
    always @(posedge clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) act_m <= 1'b0;
        else              act_m <= 1'b1;
    end

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           wq[$];
    logic [DW-1:0] rq[$];
    int            streak = 0;
    int            hold_cnt = 0;
    logic          held = 1'b0;

    int   size0;
    logic pushv, hz, forced, exp_wr, exp_rd, exp_stall;
    wr_t  e;
    logic [DW-1:0] rexp;

    // Monitor: compares outputs against the queue-based reference each cycle.
    always @(negedge clk) begin
        if (!cptra_rst_b) begin
            wq.delete();
            rq.delete();
            streak   = 0;
            held     = 1'b0;
            hold_cnt = 0;
            chk("rst_sram_cs", sram_cs, 0);
            chk("rst_level", fifo_level, 0);
        end else begin
            size0 = wq.size();
            chk("fifo_level", fifo_level, size0);
            chk("busy", busy, size0 != 0);
            chk("ext_wr_ready", ext_wr_ready, act_m && size0 < DEPTH);
            if (rq.size() > 0) begin
                rexp = rq.pop_front();
                chk("core_rdata", core_rdata, rexp);
            end
            if (!act_m) begin
                chk("idle_sram_cs", sram_cs, 0);
            end else begin
                pushv = ext_wr_valid && size0 < DEPTH;
                hz    = 1'b0;
`ifdef CALIPTRA_IMEM_ARB_FWD_EN
                if (core_cs) begin
                    foreach (wq[i])
                        if (wq[i].a == core_addr) hz = 1'b1;
                    if (pushv && ext_wr_addr == core_addr) hz = 1'b1;
                end
`endif
                forced = size0 > 0 && streak == SMAX;
                if (core_cs && !forced && !hz) begin
                    exp_wr = 1'b0; exp_rd = 1'b1; exp_stall = 1'b0;
                end else begin
                    exp_wr = size0 > 0; exp_rd = 1'b0; exp_stall = core_cs;
                end
                chk("sram_cs", sram_cs, exp_wr | exp_rd);
                chk("sram_we", sram_we, exp_wr);
                chk("core_stall", core_stall, exp_stall);
                if (exp_wr) begin
                    e = wq.pop_front();
                    chk("wr_addr", sram_addr, e.a);
                    chk("wr_data", sram_wdata, e.d);
                    shadow[e.a] = e.d;
                end
                if (exp_rd) begin
                    chk("rd_addr", sram_addr, core_addr);
                    rq.push_back(shadow[core_addr]);
                end
                streak = (exp_wr || size0 == 0) ? 0 : streak + 1;
                if (pushv) wq.push_back('{a: ext_wr_addr, d: ext_wr_data});
                held = core_cs && exp_stall;
                hold_cnt = held ? hold_cnt + 1 : 0;
                if (hold_cnt > 64) begin
                    nerr++;
                    $display("FAIL stall_timeout at %0t: held %0d cycles, limit 64",
                             $time, hold_cnt);
                    hold_cnt = 0;
                end
            end
        end
    end

    task automatic drive(input logic cs, input logic [AW-1:0] ca,
                         input logic wv, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd);
        @(posedge clk);
        #1;
        if (!held) begin
            core_cs   = cs;
            core_addr = ca;
        end
        ext_wr_valid = wv;
        ext_wr_addr  = wa;
        ext_wr_data  = wd;
    endtask

    initial begin
        cptra_rst_b  = 1'b0;
        core_cs      = 1'b0;
        core_addr    = '0;
        ext_wr_valid = 1'b0;
        ext_wr_addr  = '0;
        ext_wr_data  = '0;
        #3;
        chk("reset_ready", ext_wr_ready, 0);
        chk("reset_stall", core_stall, 0);
        chk("reset_sram_cs", sram_cs, 0);
        chk("reset_level", fifo_level, 0);
        chk("reset_busy", busy, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        cptra_rst_b = 1'b1;
        #1;
        chk("ready_pre_clk", ext_wr_ready, 0);
        @(posedge clk);
        #1;
        chk("ready_post_clk", ext_wr_ready, 1);
        chk("post_sram_cs", sram_cs, 0);

        // In-order drain on idle fetch, then read back 0x12.
        for (int i = 0; i < 4; i++)
            drive(0, 0, 1, AW'(16 + i), DW'(160 + i));
        repeat (3) drive(0, 0, 0, 0, 0);
        drive(1, 13'h12, 0, 0, 0);
        repeat (2) drive(0, 0, 0, 0, 0);

        // Continuous fetch with pushes: fills FIFO, exercises forced slots.
        for (int i = 0; i < 40; i++)
            drive(1, 13'h100, 1, AW'(13'h40 + i), {$urandom, $urandom});
        repeat (30) drive(1, 13'h101, 0, 0, 0);
        repeat (6) drive(0, 0, 0, 0, 0);

        // Fetch and write to the same address in the same cycle.
        drive(1, 13'h20, 1, 13'h20, 64'h55);
        repeat (4) drive(1, 13'h20, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 0, 0);
        drive(1, 13'h20, 0, 0, 0);
        drive(0, 0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++)
            drive($urandom_range(0, 99) < 70, AW'($urandom_range(0, 15)),
                  $urandom_range(0, 99) < 45, AW'($urandom_range(0, 15)),
                  {$urandom, $urandom});
        for (int i = 0; i < 300; i++)
            drive(1, AW'($urandom_range(0, 15)),
                  $urandom_range(0, 99) < 80, AW'($urandom_range(0, 15)),
                  {$urandom, $urandom});
        repeat (8) drive(0, 0, 0, 0, 0);

        // Reset while entries are queued and draining.
        for (int i = 0; i < 3; i++)
            drive(1, 13'h200, 1, AW'(13'h30 + i), DW'(13'h30 + i));
        drive(0, 0, 0, 0, 0);
        #2;
        cptra_rst_b = 1'b0;
        #1;
        chk("async_sram_cs", sram_cs, 0);
        chk("async_sram_we", sram_we, 0);
        chk("async_level", fifo_level, 0);
        chk("async_ready", ext_wr_ready, 0);
        chk("async_busy", busy, 0);
        repeat (3) @(posedge clk);
        #3;
        cptra_rst_b = 1'b1;
        repeat (10) drive(0, 0, 0, 0, 0);
        drive(1, 13'h31, 0, 0, 0);
        repeat (4) drive(0, 0, 0, 0, 0);
        chk("final_queue_empty", wq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
